mem_io_bridge: RTL and testbench
================================

// Module: mem_io_bridge
// PURPOSE
//   Sits directly downstream of the cpu core's byte memory bus (mem_a/mem_dout/mem_wr/mem_din).
//   Decodes each access to 128KB RAM or the I/O window (mem_a[17:16]==2'b11) and returns read data
//   one cycle later. Buffers UART TX/RX bytes in FIFOs and runs the cycle counter.
//   Generates io_buffer_full back to the core and a program-stop pulse.
// PARAMETERS
//   TX_DEPTH_LOG  4  log2 of TX FIFO depth (16 bytes)
//   RX_DEPTH_LOG  4  log2 of RX FIFO depth (16 bytes)
//   FULL_MARGIN   2  io_buffer_full asserts when TX free slots <= FULL_MARGIN
// PORTS
//   clk_in          in   1   system clock, single clock domain
//   rst_n_in        in   1   asynchronous, active-low reset
//   rdy_in          in   1   core ready; cycle counter advances only when high
//   cpu_a           in   32  cpu address bus, only [17:0] decoded
//   cpu_dout        in   8   cpu write byte
//   cpu_wr          in   1   1 = write, 0 = read (a read every cycle cpu_wr==0)
//   cpu_din         out  8   read data to cpu, valid the cycle after the address
//   io_buffer_full  out  1   TX FIFO near full
//   ram_a           out  17  RAM byte address (= cpu_a[16:0])
//   ram_we          out  1   RAM write enable (cpu_wr && !io)
//   ram_dout        out  8   RAM write byte (= cpu_dout)
//   ram_din         in   8   RAM read byte, valid the cycle after ram_a
//   tx_data         out  8   byte to UART transmitter
//   tx_valid        out  1   tx_data valid (TX FIFO not empty)
//   tx_ready        in   1   UART accepts tx_data this cycle
//   rx_data         in   8   byte from UART receiver
//   rx_valid        in   1   rx_data valid, one-cycle strobe
//   prog_stop       out  1   one-cycle pulse on write to 0x30004
// BEHAVIOUR
//   Reset: cpu_din=0, io_buffer_full=0, tx_valid=0, prog_stop=0, both FIFOs empty, counter=0,
//     io_sel_q=0, off_q=0. ram_* outputs are combinational passthrough (RAM write blocked by
//     ram_we=0 for I/O).
//   Decode io = (cpu_a[17:16]==2'b11); off = cpu_a[2:0].
//   Write 0x30000: push cpu_dout into TX FIFO; byte 0x00 ignored; push when full dropped
//     (core must honour io_buffer_full).
//   Write 0x30004: prog_stop pulses next cycle; push 0x00 into TX FIFO (pushed even if 0x00).
//   Read 0x30000: pop RX FIFO; next-cycle cpu_din = popped byte, 0x00 if FIFO was empty.
//   Read 0x30004: snapshot counter into cnt_snap; cpu_din next cycle = counter[7:0].
//   Read 0x30005..7: cpu_din = cnt_snap[15:8]/[23:16]/[31:24] (no new snapshot).
//   Other I/O offsets: reads return 0x00; writes have no effect.
//   Read latency: io_sel_q, off_q and io_rdata_q registered at the address cycle;
//     cpu_din = io_sel_q ? io_rdata_q : ram_din (1 cycle, matches RAM).
//   Cycle counter: 32-bit, +1 per clk when rdy_in, wraps 0xFFFFFFFF -> 0.
//   TX drain: tx_valid = !tx_empty; pop on tx_valid && tx_ready.
//   Simultaneous push+pop on a FIFO: both happen; count unchanged; legal at full and at empty.
//   io_buffer_full registered: 1 when (TX_DEPTH - count_next) <= FULL_MARGIN.
//   RX push on rx_valid; overflow drops the new byte.
//   Reset asserted mid-operation: FIFO contents and snapshot discarded, outputs return to
//     reset values asynchronously.
// STRUCTURE
//   Shared package (mem_io_pkg): IO_BASE 0x30000, IO_DATA off 3'd0, IO_CLK off 3'd4,
//     RAM_ABITS 17.
//   Sub-module byte_fifo (param DEPTH_LOG): push/pop/full/empty/count, ptr wrap on power of 2,
//     instantiated twice (TX and RX).
//   Top holds decode, read-return registers, counter/snapshot, prog_stop, io_buffer_full.
// TESTING
//   RAM path: write 0xA5 to 0x00010, then read 0x00010 -> cpu_din=0xA5 one cycle later,
//     ram_we=0 on read.
//   TX path: write 0x41,0x00,0x42 to 0x30000, tx_ready=1 -> tx_data emits 0x41,0x42 only.
//   Backpressure: tx_ready=0, write 14 bytes -> io_buffer_full=1 after byte 14 (16-2);
//     17th write dropped.
//   RX: rx_valid strobe with 0x5A, then read 0x30000 -> cpu_din=0x5A; second read -> 0x00.
//   Counter: force counter 0xFFFFFFFE, read 0x30004..7 over 4 cycles -> bytes of snapshot
//     0xFFFFFFFE despite wrap; rdy_in=0 freezes count.
//   Stop + reset: write 0x30004 -> prog_stop 1-cycle pulse and 0x00 on tx_data;
//     drop rst_n_in mid-drain -> tx_valid=0 at once.

Source files
------------

// File: rtl/mem_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_io_pkg
//  Description : Shared constants, decode helper and access record for the
//                cpu memory/IO bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_io_pkg;

    localparam logic [17:0] IO_BASE   = 18'h30000;
    localparam logic [2:0]  IO_DATA   = 3'd0;
    localparam logic [2:0]  IO_CLK    = 3'd4;
    localparam int          RAM_ABITS = 17;

    typedef struct packed {
        logic       io;
        logic       wr;
        logic [2:0] off;
    } access_t;

    // Only the top two decoded address bits select the I/O window.
    function automatic logic is_io(input logic [17:0] addr);
        return addr[17:16] == IO_BASE[17:16];
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : byte_fifo
//  Description : Power-of-two byte FIFO with push/pop, full/empty flags and
//                current and next-cycle occupancy.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH_LOG = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_push,
    input  logic [7:0]           i_push_data,
    input  logic                 i_pop,
    output logic [7:0]           o_pop_data,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [DEPTH_LOG:0]   o_count,
    output logic [DEPTH_LOG:0]   o_count_next
);

    localparam int                     DEPTH      = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0]     c_depth    = (DEPTH_LOG + 1)'(DEPTH);
    localparam logic [DEPTH_LOG:0]     c_cnt_one  = (DEPTH_LOG + 1)'(1);
    localparam logic [DEPTH_LOG-1:0]   c_ptr_one  = DEPTH_LOG'(1);

    logic [7:0]           r_mem [DEPTH];
    logic [DEPTH_LOG-1:0] r_wr_ptr;
    logic [DEPTH_LOG-1:0] r_rd_ptr;
    logic [DEPTH_LOG:0]   r_count;
    logic                 w_pop_en;
    logic                 w_push_en;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == c_depth);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign w_pop_en  = i_pop && !o_empty;
    assign w_push_en = i_push && (!o_full || w_pop_en);

    always_comb begin
        o_count_next = r_count;
        if (w_push_en && !w_pop_en) begin
            o_count_next = r_count + c_cnt_one;
        end else if (!w_push_en && w_pop_en) begin
            o_count_next = r_count - c_cnt_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_en) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop_en) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count <= o_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_en) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : mem_io_bridge
//  Description : Decodes cpu byte accesses into RAM or the I/O window, returns
//                read data one cycle later, buffers UART bytes, runs the cycle
//                counter and raises io_buffer_full / prog_stop.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_io_bridge
    import mem_io_pkg::*;
#(
    parameter int TX_DEPTH_LOG = 4,
    parameter int RX_DEPTH_LOG = 4,
    parameter int FULL_MARGIN  = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    input  logic [31:0]          cpu_a,
    input  logic [7:0]           cpu_dout,
    input  logic                 cpu_wr,
    output logic [7:0]           cpu_din,
    output logic                 io_buffer_full,
    output logic [RAM_ABITS-1:0] ram_a,
    output logic                 ram_we,
    output logic [7:0]           ram_dout,
    input  logic [7:0]           ram_din,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 prog_stop
);

    localparam logic [TX_DEPTH_LOG:0] c_tx_depth = (TX_DEPTH_LOG + 1)'(1 << TX_DEPTH_LOG);

    access_t               w_acc;
    logic                  w_io_rd;
    logic                  w_io_wr;
    logic                  w_tx_push;
    logic [7:0]            w_tx_push_data;
    logic                  w_tx_pop;
    logic                  w_tx_empty;
    logic                  w_tx_full;
    logic [TX_DEPTH_LOG:0] w_tx_count;
    logic [TX_DEPTH_LOG:0] w_tx_count_next;
    logic [TX_DEPTH_LOG:0] w_tx_free;
    logic                  w_rx_pop;
    logic [7:0]            w_rx_head;
    logic                  w_rx_empty;
    logic                  w_rx_full;
    logic [RX_DEPTH_LOG:0] w_rx_count;
    logic [RX_DEPTH_LOG:0] w_rx_count_next;
    logic [7:0]            w_io_rdata;
    logic                  w_snap_en;
    logic                  w_unused;

    logic                  r_io_sel;
    logic                  r_ram_sel;
    logic [7:0]            r_io_rdata;
    logic [31:0]           r_cycle_cnt;
    logic [31:0]           r_cnt_snap;
    logic                  r_prog_stop;
    logic                  r_io_buffer_full;

    always_comb begin
        w_acc     = '0;
        w_acc.io  = is_io(cpu_a[17:0]);
        w_acc.wr  = cpu_wr;
        w_acc.off = cpu_a[2:0];
    end

    assign w_io_rd = w_acc.io && !w_acc.wr;
    assign w_io_wr = w_acc.io &&  w_acc.wr;

    assign ram_a    = cpu_a[RAM_ABITS-1:0];
    assign ram_we   = cpu_wr && !w_acc.io;
    assign ram_dout = cpu_dout;

    // Data-port NUL bytes are discarded; the stop write always queues a NUL.
    assign w_tx_push      = w_io_wr && (((w_acc.off == IO_DATA) && (cpu_dout != 8'h00)) ||
                                        (w_acc.off == IO_CLK));
    assign w_tx_push_data = (w_acc.off == IO_CLK) ? 8'h00 : cpu_dout;
    assign tx_valid       = !w_tx_empty;
    assign w_tx_pop       = tx_valid && tx_ready;

    assign w_rx_pop  = w_io_rd && (w_acc.off == IO_DATA);
    assign w_snap_en = w_io_rd && (w_acc.off == IO_CLK);

    byte_fifo #(
        .DEPTH_LOG    (TX_DEPTH_LOG)
    ) u_tx_fifo (
        .clk          (clk_in),
        .rst_n        (rst_n_in),
        .i_push       (w_tx_push),
        .i_push_data  (w_tx_push_data),
        .i_pop        (w_tx_pop),
        .o_pop_data   (tx_data),
        .o_full       (w_tx_full),
        .o_empty      (w_tx_empty),
        .o_count      (w_tx_count),
        .o_count_next (w_tx_count_next)
    );

    byte_fifo #(
        .DEPTH_LOG    (RX_DEPTH_LOG)
    ) u_rx_fifo (
        .clk          (clk_in),
        .rst_n        (rst_n_in),
        .i_push       (rx_valid),
        .i_push_data  (rx_data),
        .i_pop        (w_rx_pop),
        .o_pop_data   (w_rx_head),
        .o_full       (w_rx_full),
        .o_empty      (w_rx_empty),
        .o_count      (w_rx_count),
        .o_count_next (w_rx_count_next)
    );

    // Offsets 5..7 read the frozen snapshot so a multi-byte read stays coherent.
    always_comb begin
        w_io_rdata = 8'h00;
        if (w_io_rd) begin
            case (w_acc.off)
                IO_DATA: w_io_rdata = w_rx_empty ? 8'h00 : w_rx_head;
                IO_CLK:  w_io_rdata = r_cycle_cnt[7:0];
                3'd5:    w_io_rdata = r_cnt_snap[15:8];
                3'd6:    w_io_rdata = r_cnt_snap[23:16];
                3'd7:    w_io_rdata = r_cnt_snap[31:24];
                default: w_io_rdata = 8'h00;
            endcase
        end
    end

    assign w_tx_free = c_tx_depth - w_tx_count_next;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_io_sel         <= 1'b0;
            r_ram_sel        <= 1'b0;
            r_io_rdata       <= 8'h00;
            r_cycle_cnt      <= 32'h0;
            r_cnt_snap       <= 32'h0;
            r_prog_stop      <= 1'b0;
            r_io_buffer_full <= 1'b0;
        end else begin
            r_io_sel         <= w_acc.io;
            r_ram_sel        <= !w_acc.io && !w_acc.wr;
            r_io_rdata       <= w_io_rdata;
            r_cycle_cnt      <= r_cycle_cnt + 32'(rdy_in);
            if (w_snap_en) begin
                r_cnt_snap <= r_cycle_cnt;
            end
            r_prog_stop      <= w_io_wr && (w_acc.off == IO_CLK);
            r_io_buffer_full <= (32'(w_tx_free) <= 32'(FULL_MARGIN));
        end
    end

    // RAM data is only forwarded after a RAM read so reset and writes return 0.
    assign cpu_din        = r_io_sel ? r_io_rdata : (r_ram_sel ? ram_din : 8'h00);
    assign io_buffer_full = r_io_buffer_full;
    assign prog_stop      = r_prog_stop;

    assign w_unused = &{1'b0, cpu_a[31:18], w_tx_full, w_tx_count,
                        w_rx_full, w_rx_count, w_rx_count_next};

endmodule
`default_nettype wire

// File: tb/tb_mem_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_io_bridge
//  Description : Self-checking bench for mem_io_bridge with a queue-based
//                reference model of the FIFOs, counter and read return.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_io_bridge;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic [31:0] cpu_a = 32'h0;
    logic [7:0]  cpu_dout = 8'h0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        prog_stop;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_cnt = 32'h0;
    logic [7:0]  tx_seen[$];
    logic [7:0]  ram_mem [0:131071];

    mem_io_bridge dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .rdy_in         (rdy_in),
        .cpu_a          (cpu_a),
        .cpu_dout       (cpu_dout),
        .cpu_wr         (cpu_wr),
        .cpu_din        (cpu_din),
        .io_buffer_full (io_buffer_full),
        .ram_a          (ram_a),
        .ram_we         (ram_we),
        .ram_dout       (ram_dout),
        .ram_din        (ram_din),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .prog_stop      (prog_stop)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous RAM with one-cycle read latency
    always @(posedge clk_in) begin
        if (ram_we) ram_mem[ram_a] <= ram_dout;
        ram_din <= ram_mem[ram_a];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advances one clock, logs TX handshakes and tracks the expected counter.
    task automatic tick();
        if (tx_valid && tx_ready) tx_seen.push_back(tx_data);
        @(posedge clk_in);
        if (rdy_in && rst_n_in) m_cnt = m_cnt + 32'd1;
        #1;
    endtask

    task automatic set_bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
        cpu_a    = a;
        cpu_wr   = wr;
        cpu_dout = d;
    endtask

    task automatic test_reset();
        set_bus(32'h0001_ABCD, 1'b0, 8'h00);
        repeat (3) tick();
        checks++; if (cpu_din !== 8'h00) begin errors++; $display("FAIL reset_cpu_din: got %02h expected 00", cpu_din); end
        checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", io_buffer_full); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (prog_stop !== 1'b0) begin errors++; $display("FAIL reset_prog_stop: got %b expected 0", prog_stop); end
        checks++; if (ram_a !== 17'h1ABCD) begin errors++; $display("FAIL reset_ram_a: got %05h expected 1abcd", ram_a); end
        #1 rst_n_in = 1'b1;
        set_bus(32'h0, 1'b0, 8'h00);
        tick();
    endtask

    task automatic test_ram();
        set_bus(32'h0000_0010, 1'b1, 8'hA5);
        #1;
        checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL ram_we_write: got %b expected 1", ram_we); end
        checks++; if (ram_dout !== 8'hA5) begin errors++; $display("FAIL ram_dout: got %02h expected a5", ram_dout); end
        tick();
        set_bus(32'h0000_0010, 1'b0, 8'h00);
        #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL ram_we_read: got %b expected 0", ram_we); end
        tick();
        checks++; if (cpu_din !== 8'hA5) begin errors++; $display("FAIL ram_read: got %02h expected a5", cpu_din); end
        set_bus(32'h0003_0003, 1'b1, 8'h99);
        #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL ram_we_io: got %b expected 0", ram_we); end
        tick();
        set_bus(32'h0, 1'b0, 8'h00);
        tick();
    endtask

    task automatic test_tx();
        logic [7:0] bytes [3];
        bytes = '{8'h41, 8'h00, 8'h42};
        tx_ready = 1'b1;
        tx_seen.delete();
        for (int i = 0; i < 3; i++) begin
            set_bus(32'h0003_0000, 1'b1, bytes[i]);
            tick();
        end
        set_bus(32'h0, 1'b0, 8'h00);
        repeat (5) tick();
        checks++; if (tx_seen.size() != 2) begin errors++; $display("FAIL tx_count: got %0d expected 2", tx_seen.size()); end
        checks++; if (tx_seen[0] !== 8'h41) begin errors++; $display("FAIL tx_byte0: got %02h expected 41", tx_seen[0]); end
        checks++; if (tx_seen[1] !== 8'h42) begin errors++; $display("FAIL tx_byte1: got %02h expected 42", tx_seen[1]); end
    endtask

    task automatic test_backpressure();
        tx_ready = 1'b0;
        tx_seen.delete();
        for (int i = 1; i <= 17; i++) begin
            set_bus(32'h0003_0000, 1'b1, 8'(i));
            tick();
            if (i == 13) begin
                checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL bp_full_13: got %b expected 0", io_buffer_full); end
            end
            if (i == 14) begin
                checks++; if (io_buffer_full !== 1'b1) begin errors++; $display("FAIL bp_full_14: got %b expected 1", io_buffer_full); end
            end
        end
        set_bus(32'h0, 1'b0, 8'h00);
        tx_ready = 1'b1;
        repeat (20) tick();
        checks++; if (tx_seen.size() != 16) begin errors++; $display("FAIL bp_drained: got %0d expected 16", tx_seen.size()); end
        checks++; if (tx_seen[0] !== 8'd1) begin errors++; $display("FAIL bp_first: got %02h expected 01", tx_seen[0]); end
        checks++; if (tx_seen[15] !== 8'd16) begin errors++; $display("FAIL bp_last: got %02h expected 10", tx_seen[15]); end
        checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL bp_full_clear: got %b expected 0", io_buffer_full); end
    endtask

    task automatic test_rx();
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        set_bus(32'h0003_0000, 1'b0, 8'h00);
        tick();
        checks++; if (cpu_din !== 8'h5A) begin errors++; $display("FAIL rx_read: got %02h expected 5a", cpu_din); end
        tick();
        checks++; if (cpu_din !== 8'h00) begin errors++; $display("FAIL rx_empty_read: got %02h expected 00", cpu_din); end
        set_bus(32'h0, 1'b0, 8'h00);
        tick();
    endtask

    task automatic test_counter();
        logic [31:0] snap;
        logic [7:0]  exp;
        rdy_in = 1'b0;
        force dut.r_cycle_cnt = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        tick();
        release dut.r_cycle_cnt;
        rdy_in = 1'b1;
        snap = m_cnt;
        for (int k = 4; k < 8; k++) begin
            set_bus(32'h0003_0000 | 32'(k), 1'b0, 8'h00);
            tick();
            exp = 8'(snap >> (8 * (k - 4)));
            checks++; if (cpu_din !== exp) begin errors++; $display("FAIL cnt_wrap_byte%0d: got %02h expected %02h", k - 4, cpu_din, exp); end
        end
        snap = m_cnt;
        set_bus(32'h0003_0004, 1'b0, 8'h00);
        tick();
        checks++; if (cpu_din !== snap[7:0]) begin errors++; $display("FAIL cnt_after_wrap: got %02h expected %02h", cpu_din, snap[7:0]); end
        set_bus(32'h0003_0006, 1'b0, 8'h00);
        tick();
        checks++; if (cpu_din !== snap[23:16]) begin errors++; $display("FAIL cnt_after_wrap_b2: got %02h expected %02h", cpu_din, snap[23:16]); end
        rdy_in = 1'b0;
        snap = m_cnt;
        set_bus(32'h0003_0004, 1'b0, 8'h00);
        repeat (4) tick();
        checks++; if (cpu_din !== snap[7:0]) begin errors++; $display("FAIL cnt_frozen: got %02h expected %02h", cpu_din, snap[7:0]); end
        rdy_in = 1'b1;
        set_bus(32'h0, 1'b0, 8'h00);
        tick();
    endtask

    task automatic test_random();
        logic [7:0] m_tx[$];
        logic [7:0] m_rx[$];
        logic [7:0] exp_din;
        logic [7:0] d;
        logic [16:0] addr;
        logic       exp_full;
        int         op;
        tx_ready = 1'b1;
        set_bus(32'h0, 1'b0, 8'h00);
        repeat (4) tick();
        for (int n = 0; n < 400; n++) begin
            op       = int'($urandom_range(0, 4));
            tx_ready = ($urandom_range(0, 1) == 1);
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_data  = 8'($urandom);
            d        = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            addr     = 17'($urandom_range(0, 63));
            exp_din  = 8'h00;
            case (op)
                0: set_bus(32'h0003_0000, 1'b1, d);
                1: set_bus(32'h0003_0000, 1'b0, 8'h00);
                2: set_bus(32'(addr), 1'b0, 8'h00);
                3: set_bus(32'h0003_0000 | 32'($urandom_range(1, 3)), 1'b0, 8'h00);
                default: set_bus(32'(addr), 1'b1, d);
            endcase
            #1;
            checks++; if (tx_valid !== (m_tx.size() > 0)) begin errors++; $display("FAIL rnd_tx_valid@%0d: got %b expected %b", n, tx_valid, m_tx.size() > 0); end
            if (m_tx.size() > 0 && tx_ready) begin
                checks++; if (tx_data !== m_tx[0]) begin errors++; $display("FAIL rnd_tx_data@%0d: got %02h expected %02h", n, tx_data, m_tx[0]); end
                void'(m_tx.pop_front());
            end
            if (op == 0 && d != 8'h00 && m_tx.size() < 16) m_tx.push_back(d);
            if (op == 1) exp_din = (m_rx.size() > 0) ? m_rx.pop_front() : 8'h00;
            if (rx_valid && m_rx.size() < 16) m_rx.push_back(rx_data);
            if (op == 2) exp_din = ram_mem[addr];
            exp_full = (16 - m_tx.size()) <= 2;
            tick();
            checks++; if (cpu_din !== exp_din) begin errors++; $display("FAIL rnd_cpu_din@%0d op%0d: got %02h expected %02h", n, op, cpu_din, exp_din); end
            checks++; if (io_buffer_full !== exp_full) begin errors++; $display("FAIL rnd_full@%0d: got %b expected %b", n, io_buffer_full, exp_full); end
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        set_bus(32'h0, 1'b0, 8'h00);
        repeat (20) tick();
        for (int k = 0; k < 17; k++) begin
            set_bus(32'h0003_0000, 1'b0, 8'h00);
            tick();
        end
        set_bus(32'h0, 1'b0, 8'h00);
        tick();
    endtask

    task automatic test_stop_reset();
        logic [7:0] exp;
        tx_ready = 1'b0;
        set_bus(32'h0003_0004, 1'b1, 8'h77);
        tick();
        checks++; if (prog_stop !== 1'b1) begin errors++; $display("FAIL stop_pulse: got %b expected 1", prog_stop); end
        set_bus(32'h0, 1'b0, 8'h00);
        tick();
        checks++; if (prog_stop !== 1'b0) begin errors++; $display("FAIL stop_pulse_end: got %b expected 0", prog_stop); end
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin errors++; $display("FAIL stop_tx_nul: got valid=%b data=%02h expected valid=1 data=00", tx_valid, tx_data); end
        for (int i = 1; i <= 3; i++) begin
            set_bus(32'h0003_0000, 1'b1, 8'(8'h11 * i));
            tick();
        end
        set_bus(32'h0003_0004, 1'b0, 8'h00);
        tx_ready = 1'b1;
        repeat (2) tick();
        #1 rst_n_in = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_async_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (cpu_din !== 8'h00) begin errors++; $display("FAIL rst_async_cpu_din: got %02h expected 00", cpu_din); end
        m_cnt = 32'h0;
        repeat (2) tick();
        #1 rst_n_in = 1'b1;
        set_bus(32'h0, 1'b0, 8'h00);
        tick();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_fifo_flushed: got %b expected 0", tx_valid); end
        exp = m_cnt[7:0];
        set_bus(32'h0003_0004, 1'b0, 8'h00);
        tick();
        checks++; if (cpu_din !== exp) begin errors++; $display("FAIL rst_counter: got %02h expected %02h", cpu_din, exp); end
        set_bus(32'h0003_0007, 1'b0, 8'h00);
        tick();
        checks++; if (cpu_din !== 8'h00) begin errors++; $display("FAIL rst_snap_hi: got %02h expected 00", cpu_din); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_tx();
        test_backpressure();
        test_rx();
        test_counter();
        test_random();
        test_stop_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
